// File: rtl/joy_db15_pkg.sv
// Shared constants and types for the DB15 pad-chain responder.
// Frame layout: player 1 in bits 0-11, player 2 in bits 12-23.
package joy_db15_pkg;

  localparam int FRAME_BITS  = 24;
  localparam int PLAYER_BITS = 12;

  localparam int BTN_RIGHT  = 0;
  localparam int BTN_LEFT   = 1;
  localparam int BTN_DOWN   = 2;
  localparam int BTN_UP     = 3;
  localparam int BTN_A      = 4;
  localparam int BTN_B      = 5;
  localparam int BTN_C      = 6;
  localparam int BTN_D      = 7;
  localparam int BTN_E      = 8;
  localparam int BTN_F      = 9;
  localparam int BTN_START  = 10;
  localparam int BTN_SELECT = 11;

  typedef logic [PLAYER_BITS-1:0] joy_db15_t;
  typedef logic [FRAME_BITS-1:0]  joy_frame_t;

endpackage

// File: rtl/joy_db15_responder_sync_edge.sv
// N-stage synchroniser for an asynchronous pin with level and edge outputs.
// The edge detector adds one flop, so a pin edge shows on rise/fall after STAGES clocks.
module sync_edge #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset_n,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic [STAGES-1:0] sync_reg;
  logic              prev_reg;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_reg <= {STAGES{RESET_VAL}};
      prev_reg <= RESET_VAL;
    end else begin
      sync_reg <= {sync_reg[STAGES-2:0], din};
      prev_reg <= sync_reg[STAGES-1];
    end
  end

  assign level = sync_reg[STAGES-1];
  assign rise  = level & ~prev_reg;
  assign fall  = ~level & prev_reg;

endmodule

// File: rtl/joy_db15_responder.sv
// Device-side emulation of the DB15 splitter's 24-bit shift chain, answering
// a joy_db15 reader's JOY_LOAD/JOY_CLK strobes with active-low button data.
module joy_db15_responder
  import joy_db15_pkg::*;
#(
  parameter int          SYNC_STAGES = 2,
  parameter logic [23:0] IDLE_CYCLES = 24'd4_800_000
) (
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic [PLAYER_BITS-1:0] joy1_in,
  input  logic [PLAYER_BITS-1:0] joy2_in,
  input  logic                   joy_load_in,
  input  logic                   joy_clk_in,
  output logic                   joy_data_out,
  output logic                   frame_strobe,
  output logic [4:0]             bit_count,
  output logic                   idle
);

  logic load_level, load_fall;
  logic clk_rise;

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_load_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_load_in),
    .level   (load_level),
    .rise    (),
    .fall    (load_fall)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_clk_sync (
    .clk     (clk),
    .reset_n (reset_n),
    .din     (joy_clk_in),
    .level   (),
    .rise    (clk_rise),
    .fall    ()
  );

  // Parallel-load image: buttons are active-low on the wire.
  joy_frame_t load_word;
  genvar gi;
  generate
    for (gi = 0; gi < PLAYER_BITS; gi++) begin : g_load_word
      assign load_word[gi]               = ~joy1_in[gi];
      assign load_word[gi + PLAYER_BITS] = ~joy2_in[gi];
    end
  endgenerate

  joy_frame_t  shreg_reg, shreg_next;
  logic [4:0]  bit_count_reg, bit_count_next;
  logic        strobe_reg, strobe_next;
  logic [23:0] idle_cnt_reg, idle_cnt_next;

  always_comb begin
    shreg_next     = shreg_reg;
    bit_count_next = bit_count_reg;
    strobe_next    = 1'b0;
    idle_cnt_next  = idle_cnt_reg;

    // Load is transparent while low and overrides any coincident clock edge.
    if (!load_level) begin
      shreg_next     = load_word;
      bit_count_next = 5'd0;
    end else if (clk_rise) begin
      shreg_next = {1'b1, shreg_reg[FRAME_BITS-1:1]};
      if (bit_count_reg < 5'(FRAME_BITS)) begin
        bit_count_next = bit_count_reg + 5'd1;
        strobe_next    = (bit_count_reg == 5'(FRAME_BITS - 1));
      end
    end

    if (load_fall) begin
      idle_cnt_next = 24'd0;
    end else if (idle_cnt_reg != IDLE_CYCLES) begin
      idle_cnt_next = idle_cnt_reg + 24'd1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      shreg_reg     <= '1;
      bit_count_reg <= 5'd0;
      strobe_reg    <= 1'b0;
      idle_cnt_reg  <= IDLE_CYCLES;
    end else begin
      shreg_reg     <= shreg_next;
      bit_count_reg <= bit_count_next;
      strobe_reg    <= strobe_next;
      idle_cnt_reg  <= idle_cnt_next;
    end
  end

  assign joy_data_out = shreg_reg[0];
  assign frame_strobe = strobe_reg;
  assign bit_count    = bit_count_reg;
  assign idle         = (idle_cnt_reg == IDLE_CYCLES);

endmodule

// File: tb/tb_joy_db15_responder.sv
// Directed bench for joy_db15_responder: table of pad vectors read back as
// full frames, plus sequences for abort, load/clk collision, idle and reset.
module tb_joy_db15_responder;

  logic        clk = 1'b0;
  logic        reset_n;
  logic [11:0] joy1_in;
  logic [11:0] joy2_in;
  logic        joy_load_in;
  logic        joy_clk_in;
  logic        joy_data_out;
  logic        frame_strobe;
  logic [4:0]  bit_count;
  logic        idle;

  int tests_run    = 0;
  int tests_failed = 0;
  int strobe_cnt   = 0;

  always #5 clk = ~clk;

  joy_db15_responder #(
    .SYNC_STAGES (2),
    .IDLE_CYCLES (24'd100)
  ) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .joy1_in      (joy1_in),
    .joy2_in      (joy2_in),
    .joy_load_in  (joy_load_in),
    .joy_clk_in   (joy_clk_in),
    .joy_data_out (joy_data_out),
    .frame_strobe (frame_strobe),
    .bit_count    (bit_count),
    .idle         (idle)
  );

  always @(negedge clk) begin
    if (frame_strobe === 1'b1) strobe_cnt <= strobe_cnt + 1;
  end

  typedef struct {
    logic [11:0] j1;
    logic [11:0] j2;
    logic [23:0] exp_frame;
  } vec_t;

  vec_t vecs[5];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic do_load();
    @(negedge clk) joy_load_in = 1'b0;
    repeat (4) @(negedge clk);
    joy_load_in = 1'b1;
    repeat (4) @(negedge clk);
  endtask

  task automatic pulse();
    @(negedge clk) joy_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    joy_clk_in = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  // Reader view: bit 0 is valid after load, each clock exposes the next bit.
  task automatic read_frame(output logic [23:0] w);
    w[0] = joy_data_out;
    for (int i = 1; i < 24; i++) begin
      pulse();
      w[i] = joy_data_out;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [23:0] w;
    logic [5:0]  extra;
    int          s0;
    int          found;

    vecs[0] = '{12'h001, 12'h000, 24'hFFFFFE};
    vecs[1] = '{12'hA5A, 12'h3C3, 24'hC3C5A5};
    vecs[2] = '{12'hFFF, 12'hFFF, 24'h000000};
    vecs[3] = '{12'h000, 12'h000, 24'hFFFFFF};
    vecs[4] = '{12'h800, 12'h001, 24'hFFE7FF};

    reset_n     = 1'b0;
    joy1_in     = 12'h000;
    joy2_in     = 12'h000;
    joy_load_in = 1'b1;
    joy_clk_in  = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_data", 32'(joy_data_out), 32'd1);
    check("reset_bit_count", 32'(bit_count), 32'd0);
    check("reset_strobe", 32'(frame_strobe), 32'd0);
    check("reset_idle", 32'(idle), 32'd1);
    reset_n = 1'b1;
    repeat (3) @(negedge clk);
    check("post_release_idle", 32'(idle), 32'd1);

    for (int v = 0; v < 5; v++) begin
      joy1_in = vecs[v].j1;
      joy2_in = vecs[v].j2;
      s0 = strobe_cnt;
      do_load();
      read_frame(w);
      check("frame_bits", 32'(w), 32'(vecs[v].exp_frame));
      check("count_before_last", 32'(bit_count), 32'd23);
      pulse();
      check("count_full", 32'(bit_count), 32'd24);
      for (int i = 0; i < 6; i++) begin
        pulse();
        extra[i] = joy_data_out;
      end
      check("extra_ones", 32'(extra), 32'h3F);
      check("strobe_once", 32'(strobe_cnt - s0), 32'd1);
      check("count_saturated", 32'(bit_count), 32'd24);
      $display("[TB] vec %0d j1=%h j2=%h frame=%h strobes=%0d", v, vecs[v].j1, vecs[v].j2,
               w, strobe_cnt - s0);
    end

    // Abort after 10 clocks, then a fresh frame.
    joy1_in = 12'hA5A;
    joy2_in = 12'h3C3;
    s0 = strobe_cnt;
    do_load();
    repeat (10) pulse();
    check("abort_count_10", 32'(bit_count), 32'd10);
    joy1_in = 12'h001;
    joy2_in = 12'h000;
    @(negedge clk) joy_load_in = 1'b0;
    repeat (4) @(negedge clk);
    check("abort_count_zero", 32'(bit_count), 32'd0);
    joy_load_in = 1'b1;
    repeat (4) @(negedge clk);
    read_frame(w);
    pulse();
    check("abort_next_frame", 32'(w), 32'hFFFFFE);
    check("abort_strobe_count", 32'(strobe_cnt - s0), 32'd1);
    $display("[TB] abort frame=%h strobes=%0d", w, strobe_cnt - s0);

    // Clock rising in the same cycle that load falls: load must win.
    do_load();
    repeat (3) pulse();
    joy1_in = 12'h002;
    @(negedge clk);
    joy_load_in = 1'b0;
    joy_clk_in  = 1'b1;
    repeat (4) @(negedge clk);
    joy_load_in = 1'b1;
    repeat (4) @(negedge clk);
    check("collide_count", 32'(bit_count), 32'd0);
    check("collide_bit0", 32'(joy_data_out), 32'd1);
    joy_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    joy_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    check("collide_bit1", 32'(joy_data_out), 32'd0);
    check("collide_count1", 32'(bit_count), 32'd1);
    joy_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] collision count=%0d data=%b", bit_count, joy_data_out);

    // Idle: let the counter saturate, then one load falling edge.
    repeat (110) @(negedge clk);
    check("idle_saturated", 32'(idle), 32'd1);
    @(negedge clk) joy_load_in = 1'b0;
    found = -1;
    for (int k = 1; k <= 300 && found < 0; k++) begin
      @(negedge clk);
      if (k == 4) joy_load_in = 1'b1;
      if (k == 2) check("idle_before_clear", 32'(idle), 32'd1);
      if (k == 3) check("idle_cleared", 32'(idle), 32'd0);
      if (k > 3 && idle === 1'b1) found = k;
    end
    check("idle_rise_cycle", 32'(found), 32'd103);
    $display("[TB] idle rose %0d cycles after load pin fell", found);

    // Async reset at bit 12 with the clock pin high across release.
    joy1_in = 12'hA5A;
    joy2_in = 12'h3C3;
    do_load();
    repeat (12) pulse();
    check("pre_reset_bit12", 32'(joy_data_out), 32'd0);
    check("pre_reset_count", 32'(bit_count), 32'd12);
    @(negedge clk) joy_clk_in = 1'b1;
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1;
    check("async_reset_data", 32'(joy_data_out), 32'd1);
    check("async_reset_count", 32'(bit_count), 32'd0);
    check("async_reset_idle", 32'(idle), 32'd1);
    repeat (3) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    check("no_spurious_shift", 32'(bit_count), 32'd0);
    check("post_reset_data", 32'(joy_data_out), 32'd1);
    joy_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    joy_clk_in = 1'b1;
    repeat (4) @(negedge clk);
    check("post_reset_shift_count", 32'(bit_count), 32'd1);
    check("post_reset_shift_data", 32'(joy_data_out), 32'd1);
    joy_clk_in = 1'b0;
    repeat (4) @(negedge clk);
    $display("[TB] reset mid-frame count=%0d data=%b", bit_count, joy_data_out);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
